// File: rtl/signal_gen_pkg.sv
// signal_gen_pkg: MCP4822 command-word layout, FSM states and word builder shared by sample generators.
package signal_gen_pkg;
  localparam int CHAN_BIT = 15;
  localparam int GA_BIT = 13;
  localparam int SHDN_BIT = 12;
  localparam int DATA_MSB = 11;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_LATCH = 2'd2;
  // GA is active-low on the DAC: 0 selects 2x gain.
  function automatic logic [15:0] mcp4822_word(input logic chan, input logic gain2x, input logic shdn_n,
                                               input logic [11:0] data);
    logic [15:0] w;
    w = '0;
    w[CHAN_BIT] = chan;
    w[GA_BIT] = ~gain2x;
    w[SHDN_BIT] = shdn_n;
    w[DATA_MSB:0] = data;
    return w;
  endfunction
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: free-running 0..SPI_DIV-1 divider with a terminal-count tick, held at zero by clear.
module spi_tick_gen #(
  parameter int SPI_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  output logic       tick,
  output logic [7:0] cnt
);
  logic [7:0] cnt_q, cnt_d;
  assign tick = cnt_q == 8'(SPI_DIV - 1);
  assign cnt = cnt_q;
  always_comb cnt_d = (clear || tick) ? 8'd0 : cnt_q + 8'd1;
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
endmodule

// File: rtl/mcp4822_spi_tx.sv
// mcp4822_spi_tx: one sample per handshake, shifted MSB-first on SPI mode 0, then an LDAC strobe.
module mcp4822_spi_tx
  import signal_gen_pkg::*;
#(
  parameter int SPI_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data,
  input  logic        s_chan,
  input  logic        s_gain2x,
  input  logic        s_shdn_n,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        ldac_n,
  output logic        frame_done
);
  state_t state_q, state_d;
  logic [15:0] word_q, word_d, cmd;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
  logic frame_done_q, frame_done_d, s_ready_q, s_ready_d, tick;
  logic [7:0] cnt;
  spi_tick_gen #(.SPI_DIV(SPI_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == ST_IDLE),
    .tick (tick),
    .cnt  (cnt)
  );
  assign cmd = mcp4822_word(s_chan, s_gain2x, s_shdn_n, s_data);
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    bit_idx_d = bit_idx_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    cs_n_d = cs_n_q;
    ldac_n_d = ldac_n_q;
    s_ready_d = s_ready_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          state_d = ST_SHIFT;
          word_d = cmd;
          bit_idx_d = 4'd15;
          cs_n_d = 1'b0;
          mosi_d = cmd[15];
          s_ready_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sck_d = ~sck_q;
          // data only moves on the falling toggle, giving a full half-period of setup and hold
          if (sck_q) begin
            if (bit_idx_q == 4'd0) begin
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
              ldac_n_d = 1'b0;
              state_d = ST_LATCH;
            end else begin
              bit_idx_d = bit_idx_q - 4'd1;
              mosi_d = word_q[bit_idx_q - 4'd1];
            end
          end
        end
      end
      ST_LATCH: begin
        // registered pulse lands on the final LDAC-low cycle
        frame_done_d = cnt == 8'(SPI_DIV - 2);
        if (tick) begin
          ldac_n_d = 1'b1;
          s_ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q <= '0;
      bit_idx_q <= '0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      ldac_n_q <= 1'b1;
      frame_done_q <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      bit_idx_q <= bit_idx_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
      ldac_n_q <= ldac_n_d;
      frame_done_q <= frame_done_d;
      s_ready_q <= s_ready_d;
    end
  end
  assign s_ready = s_ready_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sck = sck_q;
  assign spi_mosi = mosi_q;
  assign ldac_n = ldac_n_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_mcp4822_spi_tx.sv
// tb_mcp4822_spi_tx: scoreboard bench for SPI_DIV=8 (instance 0) and SPI_DIV=2 (instance 1).
module tb_mcp4822_spi_tx;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] s_valid = '0, s_chan = '0, s_gain2x = '0, s_shdn_n = '0;
  logic [11:0] s_data [2];
  logic [1:0] s_ready, cs_n, sck, mosi, ldac_n, frame_done;
  logic [15:0] exp_q [2][$];
  int checks = 0, errors = 0, cyc = 0;
  int frames [2];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int D = (g == 0) ? 8 : 2;
    mcp4822_spi_tx #(.SPI_DIV(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid[g]),
      .s_ready   (s_ready[g]),
      .s_data    (s_data[g]),
      .s_chan    (s_chan[g]),
      .s_gain2x  (s_gain2x[g]),
      .s_shdn_n  (s_shdn_n[g]),
      .spi_cs_n  (cs_n[g]),
      .spi_sck   (sck[g]),
      .spi_mosi  (mosi[g]),
      .ldac_n    (ldac_n[g]),
      .frame_done(frame_done[g])
    );
    int cs_len = 0, ldac_len = 0, fd_cnt = 0, nbits = 0;
    logic [15:0] sh = '0, e;
    logic pcs = 1'b1, psck = 1'b0, pldac = 1'b1, pmosi = 1'b0;
    always @(negedge clk) begin
      if (rst) begin
        if (!pcs && cs_n[g] && exp_q[g].size() > 0) void'(exp_q[g].pop_front());
        cs_len = 0;
        ldac_len = 0;
        fd_cnt = 0;
        nbits = 0;
      end else begin
        if (!cs_n[g]) cs_len++;
        if (!ldac_n[g]) ldac_len++;
        if (frame_done[g]) begin
          fd_cnt++;
          chk("frame_done_pos", ldac_len, D);
        end
        if (mosi[g] !== pmosi && !pcs && !cs_n[g]) chk("mosi_on_fall", psck && !sck[g], 1);
        if (!psck && sck[g] && !cs_n[g]) begin
          sh = {sh[14:0], mosi[g]};
          nbits++;
        end
        if (!pcs && cs_n[g]) begin
          chk("cs_low_len", cs_len, 32 * D);
          chk("sck_rises", nbits, 16);
          chk("sck_at_cs_rise", sck[g], 0);
          chk("ldac_with_cs", ldac_n[g], 0);
          chk("frame_expected", exp_q[g].size() > 0, 1);
          e = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : 16'hxxxx;
          chk("word", sh, e);
          cs_len = 0;
          nbits = 0;
        end
        if (!pldac && ldac_n[g]) begin
          chk("ldac_len", ldac_len, D);
          chk("frame_done_count", fd_cnt, 1);
          frames[g]++;
          ldac_len = 0;
          fd_cnt = 0;
        end
      end
      pcs = cs_n[g];
      psck = sck[g];
      pldac = ldac_n[g];
      pmosi = mosi[g];
    end
  end

  task automatic wait_ready(input int i);
    for (int k = 0; k < 3000 && !s_ready[i]; k++) @(negedge clk);
    chk("ready_timeout", s_ready[i], 1);
  endtask

  task automatic send(input int i, input logic ch, input logic g2, input logic sd, input logic [11:0] d,
                      input logic [15:0] w);
    @(negedge clk);
    s_chan[i] = ch;
    s_gain2x[i] = g2;
    s_shdn_n[i] = sd;
    s_data[i] = d;
    s_valid[i] = 1'b1;
    wait_ready(i);
    exp_q[i].push_back(w);
    @(negedge clk);
    s_valid[i] = 1'b0;
    s_data[i] = 12'h5A5;
    chk("cs_fall", cs_n[i], 0);
    chk("first_bit", mosi[i], w[15]);
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 3000 && (exp_q[i].size() != 0 || !s_ready[i]); k++) @(negedge clk);
    chk("idle_timeout", s_ready[i], 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic b2b(input int i, input int d, input int n, input logic [11:0] base, input logic [15:0] wbase);
    int prev;
    @(negedge clk);
    s_chan[i] = 1'b0;
    s_gain2x[i] = 1'b0;
    s_shdn_n[i] = 1'b1;
    s_data[i] = base;
    s_valid[i] = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_ready(i);
      exp_q[i].push_back(wbase + 16'(k));
      if (k > 0) chk("handshake_gap", cyc - prev, 33 * d + 1);
      prev = cyc;
      @(negedge clk);
      if (k == n - 1) s_valid[i] = 1'b0;
      s_data[i] = 12'hEEE;
      for (int j = 0; j < 3000 && !frame_done[i]; j++) @(negedge clk);
      s_data[i] = base + 12'(k + 1);
    end
  endtask

  initial begin
    frames[0] = 0;
    frames[1] = 0;
    s_data[0] = '0;
    s_data[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", cs_n[i], 1);
      chk("rst_sck", sck[i], 0);
      chk("rst_mosi", mosi[i], 0);
      chk("rst_ldac_n", ldac_n[i], 1);
      chk("rst_frame_done", frame_done[i], 0);
      chk("rst_ready", s_ready[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", s_ready[0], 1);
    send(0, 1'b0, 1'b0, 1'b1, 12'hA5C, 16'h3A5C);
    wait_idle(0);
    chk("frames_a", frames[0], 1);
    send(0, 1'b1, 1'b1, 1'b0, 12'hFFF, 16'h8FFF);
    send(0, 1'b1, 1'b1, 1'b1, 12'h000, 16'h9000);
    wait_idle(0);
    b2b(0, 8, 4, 12'h100, 16'h3100);
    wait_idle(0);
    chk("frames_b2b", frames[0], 7);
    send(0, 1'b0, 1'b0, 1'b1, 12'h123, 16'h3123);
    repeat (50) @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0] = 12'hBAD;
    @(negedge clk);
    s_valid[0] = 1'b0;
    for (int j = 0; j < 3000 && ldac_n[0]; j++) @(negedge clk);
    s_valid[0] = 1'b1;
    @(negedge clk);
    s_valid[0] = 1'b0;
    wait_idle(0);
    repeat (300) @(negedge clk);
    chk("no_extra_frame", frames[0], 8);
    send(0, 1'b0, 1'b1, 1'b1, 12'h777, 16'h1777);
    begin
      int edges = 0;
      logic ps;
      ps = sck[0];
      for (int j = 0; j < 3000 && edges < 7; j++) begin
        @(negedge clk);
        if (sck[0] !== ps) edges++;
        ps = sck[0];
      end
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", cs_n[0], 1);
    chk("abort_sck", sck[0], 0);
    chk("abort_mosi", mosi[0], 0);
    chk("abort_ldac_n", ldac_n[0], 1);
    chk("abort_ready", s_ready[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(0, 1'b0, 1'b0, 1'b1, 12'hC3A, 16'h3C3A);
    wait_idle(0);
    chk("frames_after_abort", frames[0], 9);
    send(1, 1'b0, 1'b0, 1'b1, 12'h5A5, 16'h35A5);
    wait_idle(1);
    b2b(1, 2, 3, 12'h0F0, 16'h30F0);
    wait_idle(1);
    chk("frames_div2", frames[1], 4);
    chk("queue0_empty", exp_q[0].size(), 0);
    chk("queue1_empty", exp_q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
